// File: rtl/counter_sequencer.sv
// Sequences an external 8-bit counter through `reps` repetitions of 0..period,
// with a clear cycle before each repetition, abort on stop and a fault check.
module counter_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] period,
    input  logic [3:0] reps,
    input  logic [7:0] cnt_count,
    input  logic       cnt_tc,
    output logic       cnt_rst,
    output logic       cnt_en,
    output logic       busy,
    output logic       tick,
    output logic       done,
    output logic       err,
    output logic [3:0] rep_left
);

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] period_q;
    logic       err_q;
    logic       match, fault, accept, reject;

    assign match = (state == RUN) && (cnt_count == period_q);
    // A wrapped counter that never met period_q; a period of 255 ends on a match instead.
    assign fault = (state == RUN) && cnt_tc && !match;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (period != 8'd0 && reps != 4'd0) begin
                        accept   = 1'b1;
                        state_nx = CLR;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            CLR:  state_nx = stop ? IDLE : RUN;
            RUN: begin
                if (stop)
                    state_nx = IDLE;
                else if (match)
                    state_nx = (rep_left == 4'd1) ? DONE : CLR;
                else if (fault)
                    state_nx = IDLE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            period_q <= 8'd0;
            rep_left <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= reject || (fault && !stop);
            if (accept) begin
                period_q <= period;
                rep_left <= reps;
            end else if (match && !stop) begin
                rep_left <= rep_left - 4'd1;
            end
        end
    end

    // The counter is held clear for the whole reset window, not just after the edge.
    assign cnt_rst = !rst || (state == CLR);
    assign cnt_en  = rst && (state == RUN) && !match && !stop;
    assign busy    = (state == CLR) || (state == RUN);
    assign tick    = match;
    assign done    = (state == DONE);
    assign err     = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [7:0] period;
    logic [3:0] reps;
    logic [7:0] cnt;
    logic       cnt_rst, cnt_en, busy, tick, done, err;
    logic [3:0] rep_left;
    logic       jump;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] p_cr, p_ce, p_bz, p_tk, p_dn, p_er;
    int          n_tk, n_dn, n_er;
    logic [7:0]  cc  [0:300];
    logic [3:0]  rl  [0:300];
    logic        tka [0:300];
    logic        cea [0:300];
    logic        dna [0:300];

    counter_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .period   (period),
        .reps     (reps),
        .cnt_count(cnt),
        .cnt_tc   (cnt == 8'hFF),
        .cnt_rst  (cnt_rst),
        .cnt_en   (cnt_en),
        .busy     (busy),
        .tick     (tick),
        .done     (done),
        .err      (err),
        .rep_left (rep_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_rst)     cnt <= 8'd0;
        else if (jump)   cnt <= 8'hFF;
        else if (cnt_en) cnt <= cnt + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n, input int stop_at, input int jump_at,
                       input int start2_at, input logic [7:0] p2, input logic [3:0] r2);
        p_cr = '0; p_ce = '0; p_bz = '0; p_tk = '0; p_dn = '0; p_er = '0;
        n_tk = 0; n_dn = 0; n_er = 0;
        for (int k = 0; k <= n; k++) begin
            start = (k == 0) || (k == start2_at);
            stop  = (k == stop_at);
            jump  = (k == jump_at);
            if (k == start2_at) begin
                period = p2;
                reps   = r2;
            end
            @(negedge clk);
            if (k < 16) begin
                p_cr[k] = cnt_rst; p_ce[k] = cnt_en; p_bz[k] = busy;
                p_tk[k] = tick;    p_dn[k] = done;   p_er[k] = err;
            end
            cc[k] = cnt; rl[k] = rep_left; tka[k] = tick; cea[k] = cnt_en; dna[k] = done;
            n_tk += int'(tick); n_dn += int'(done); n_er += int'(err);
            @(posedge clk); #1;
        end
        start = 1'b0; stop = 1'b0; jump = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; jump = 1'b0;
        period = 8'd0; reps = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_cnt_rst", cnt_rst, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {tick, done, err, cnt_en}, 4'b0000);
        chk("rst_rep_left", rep_left, 4'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_cnt_rst", cnt_rst, 1'b0);
        @(posedge clk); #1;

        period = 8'd3; reps = 4'd2;
        run(12, 11, -1, -1, 8'd0, 4'd0);
        chk("basic_cnt_rst", p_cr, 16'h0042);
        chk("basic_tick", p_tk, 16'h0420);
        chk("basic_done", p_dn, 16'h0800);
        chk("basic_busy", p_bz, 16'h07FE);
        chk("basic_cnt_en", p_ce, 16'h039C);
        chk("basic_err", p_er, 16'h0000);
        chk("basic_cnt_hold", cc[5], 8'd3);
        chk("basic_rl_c3", rl[3], 4'd2);
        chk("basic_rl_c8", rl[8], 4'd1);
        chk("basic_rl_c12", rl[12], 4'd0);

        period = 8'd0; reps = 4'd5;
        run(4, -1, -1, -1, 8'd0, 4'd0);
        chk("rej_p0_err", p_er, 16'h0002);
        chk("rej_p0_busy", p_bz, 16'h0000);
        chk("rej_p0_cnt_en", p_ce, 16'h0000);
        chk("rej_p0_rl", rl[4], 4'd0);
        period = 8'd4; reps = 4'd0;
        run(4, -1, -1, -1, 8'd0, 4'd0);
        chk("rej_r0_err", p_er, 16'h0002);
        chk("rej_r0_busy", p_bz, 16'h0000);

        period = 8'd10; reps = 4'd3;
        run(10, 7, -1, -1, 8'd0, 4'd0);
        chk("abort_cnt_en", p_ce, 16'h007C);
        chk("abort_busy", p_bz, 16'h00FE);
        chk("abort_tick_done", {p_tk, p_dn}, 32'h0);
        chk("abort_err", p_er, 16'h0000);
        chk("abort_rl", rl[9], 4'd3);

        period = 8'd2; reps = 4'd1;
        run(7, 4, -1, -1, 8'd0, 4'd0);
        chk("stopmatch_tick", p_tk, 16'h0010);
        chk("stopmatch_done", p_dn, 16'h0000);
        chk("stopmatch_busy", p_bz, 16'h001E);
        chk("stopmatch_rl", rl[6], 4'd1);

        period = 8'd255; reps = 4'd1;
        run(260, -1, -1, -1, 8'd0, 4'd0);
        chk("full_cnt_255", cc[257], 8'd255);
        chk("full_tick_257", tka[257], 1'b1);
        chk("full_tick_count", n_tk, 1);
        chk("full_err_count", n_er, 0);
        chk("full_done_258", dna[258], 1'b1);
        chk("full_done_count", n_dn, 1);
        chk("full_en_256", cea[256], 1'b1);
        chk("full_en_257", cea[257], 1'b0);

        period = 8'd20; reps = 4'd2;
        run(10, -1, 4, -1, 8'd0, 4'd0);
        chk("fault_cnt", cc[5], 8'd255);
        chk("fault_err", p_er, 16'h0040);
        chk("fault_busy", p_bz, 16'h003E);
        chk("fault_done", n_dn, 0);
        chk("fault_tick", n_tk, 0);

        period = 8'd5; reps = 4'd2;
        run(4, -1, -1, 3, 8'd1, 4'd1);
        chk("busy_start_en", p_ce, 16'h001C);
        chk("busy_start_busy", p_bz, 16'h001E);
        chk("busy_param_cnt", cc[4], 8'd2);
        chk("busy_param_rl", rl[4], 4'd2);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cnt_rst_pre", cnt_rst, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_flags", {tick, done, err, cnt_en}, 4'b0000);
        chk("midrst_rl", rep_left, 4'd0);
        chk("midrst_cnt_rst", cnt_rst, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        period = 8'd2; reps = 4'd1;
        run(6, -1, -1, -1, 8'd0, 4'd0);
        chk("retrig_cnt_rst", p_cr, 16'h0002);
        chk("retrig_tick", p_tk, 16'h0010);
        chk("retrig_done", p_dn, 16'h0020);
        chk("retrig_err", p_er, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
